// File: rtl/shftreg_univ.sv
// shftreg_univ: parametrised universal shift register with logical/rotate/arithmetic modes,
// serial-out, and a burst sequencer that shifts cnt_i positions with busy/done handshake.
module shftreg_univ #(
    parameter int WIDTH = 4,
    parameter int CNTW  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] inp_i,
    input  logic             en_i,
    input  logic             rl_i,
    input  logic [1:0]       mode_i,
    input  logic             ins_i,
    input  logic             start_i,
    input  logic [CNTW-1:0]  cnt_i,
    output logic [WIDTH-1:0] d_o,
    output logic             outs_o,
    output logic             busy_o,
    output logic             done_o
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q;
    logic [WIDTH-1:0] d_q, sh_d;
    logic [CNTW-1:0]  cnt_q;
    logic [1:0]       mode_q, mode_d;
    logic             rl_q, rl_d, outs_q, busy_q, done_q, fill, sh_out, hold;
    // a running burst uses its latched direction/mode; single steps use the live inputs
    always_comb begin
        rl_d   = state_q == SHIFT ? rl_q : rl_i;
        mode_d = state_q == SHIFT ? mode_q : mode_i;
        hold   = mode_d == 2'b11;
        fill   = mode_d == 2'b00 ? ins_i :
                 mode_d == 2'b01 ? (rl_d ? d_q[0] : d_q[WIDTH-1]) :
                 (rl_d ? d_q[WIDTH-1] : 1'b0);
        sh_d   = rl_d ? {fill, d_q[WIDTH-1:1]} : {d_q[WIDTH-2:0], fill};
        sh_out = rl_d ? d_q[0] : d_q[WIDTH-1];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            d_q     <= '0;
            cnt_q   <= '0;
            rl_q    <= 1'b0;
            mode_q  <= 2'b00;
            outs_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else if (state_q == SHIFT) begin
            if (!hold) begin
                d_q    <= sh_d;
                outs_q <= sh_out;
            end
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == 1) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
            end
        end else begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            if (ld_i) begin
                d_q <= inp_i;
            end else if (start_i) begin
                if (cnt_i != 0) begin
                    state_q <= SHIFT;
                    cnt_q   <= cnt_i;
                    rl_q    <= rl_i;
                    mode_q  <= mode_i;
                    busy_q  <= 1'b1;
                end else begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
            end else if (en_i && !hold) begin
                d_q    <= sh_d;
                outs_q <= sh_out;
            end
        end
    end
    assign d_o    = d_q;
    assign outs_o = outs_q;
    assign busy_o = busy_q;
    assign done_o = done_q;
endmodule

// File: tb/tb_shftreg_univ.sv
// tb_shftreg_univ: scoreboard bench for shftreg_univ at WIDTH=4, CNTW=3.
module tb_shftreg_univ;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic       ld_i = 1'b0, en_i = 1'b0, rl_i = 1'b0, ins_i = 1'b0, start_i = 1'b0;
    logic [3:0] inp_i = '0;
    logic [1:0] mode_i = 2'b00;
    logic [2:0] cnt_i = '0;
    logic [3:0] d_o;
    logic       outs_o, busy_o, done_o;
    int         checks = 0, errors = 0;
    typedef struct {
        string      tag;
        logic [3:0] d;
        logic       o, b, dn;
    } exp_t;
    exp_t sbq[$];
    shftreg_univ #(.WIDTH(4), .CNTW(3)) dut (
        .clk(clk), .rst_n(rst_n), .ld_i(ld_i), .inp_i(inp_i), .en_i(en_i), .rl_i(rl_i),
        .mode_i(mode_i), .ins_i(ins_i), .start_i(start_i), .cnt_i(cnt_i),
        .d_o(d_o), .outs_o(outs_o), .busy_o(busy_o), .done_o(done_o)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask
    task automatic push(input string tag, input logic [3:0] d, input logic o, b, dn);
        exp_t e;
        e.tag = tag; e.d = d; e.o = o; e.b = b; e.dn = dn;
        sbq.push_back(e);
    endtask
    task automatic pop_cmp();
        exp_t e;
        e = sbq.pop_front();
        chk({e.tag, ".d"}, 32'(d_o), 32'(e.d));
        chk({e.tag, ".outs"}, 32'(outs_o), 32'(e.o));
        chk({e.tag, ".busy"}, 32'(busy_o), 32'(e.b));
        chk({e.tag, ".done"}, 32'(done_o), 32'(e.dn));
    endtask
    task automatic now(input string tag, input logic [3:0] d, input logic o, b, dn);
        push(tag, d, o, b, dn);
        pop_cmp();
    endtask
    task automatic cyc(input string tag, input logic [3:0] d, input logic o, b, dn);
        push(tag, d, o, b, dn);
        @(posedge clk);
        #1;
        pop_cmp();
    endtask
    task automatic burst(input logic [2:0] c, input logic [1:0] m, input logic r);
        start_i = 1'b1; cnt_i = c; mode_i = m; rl_i = r;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        now("reset", 4'b0000, 0, 0, 0);
        rst_n = 1'b1;
        ld_i = 1'b1; inp_i = 4'b0101;
        cyc("ld0101", 4'b0101, 0, 0, 0);
        ld_i = 1'b0; mode_i = 2'b00; rl_i = 1'b1; ins_i = 1'b1; en_i = 1'b1;
        cyc("en_log1", 4'b1010, 1, 0, 0);
        cyc("en_log2", 4'b1101, 0, 0, 0);
        en_i = 1'b0;
        ld_i = 1'b1; inp_i = 4'b1001;
        cyc("ld1001", 4'b1001, 0, 0, 0);
        ld_i = 1'b0;
        burst(3, 2'b01, 1'b0);
        cyc("rot_start", 4'b1001, 0, 1, 0);
        start_i = 1'b0; mode_i = 2'b11; rl_i = 1'b1;
        cyc("rot1", 4'b0011, 1, 1, 0);
        cyc("rot2", 4'b0110, 0, 1, 0);
        cyc("rot3", 4'b1100, 0, 0, 1);
        cyc("rot_idle", 4'b1100, 0, 0, 0);
        ld_i = 1'b1; inp_i = 4'b1000;
        cyc("ld1000", 4'b1000, 0, 0, 0);
        ld_i = 1'b0;
        burst(2, 2'b10, 1'b1);
        cyc("ari_start", 4'b1000, 0, 1, 0);
        start_i = 1'b0;
        cyc("ari1", 4'b1100, 0, 1, 0);
        cyc("ari2", 4'b1110, 0, 0, 1);
        cyc("ari_idle", 4'b1110, 0, 0, 0);
        burst(0, 2'b00, 1'b0);
        cyc("cnt0", 4'b1110, 0, 0, 1);
        start_i = 1'b0;
        cyc("cnt0_idle", 4'b1110, 0, 0, 0);
        burst(2, 2'b01, 1'b1);
        cyc("ign_start", 4'b1110, 0, 1, 0);
        ld_i = 1'b1; inp_i = 4'b1111; en_i = 1'b1; start_i = 1'b1; cnt_i = 3'd5; mode_i = 2'b00;
        cyc("ign1", 4'b0111, 0, 1, 0);
        cyc("ign2", 4'b1011, 1, 0, 1);
        ld_i = 1'b0; en_i = 1'b0; start_i = 1'b0;
        cyc("ign_idle", 4'b1011, 1, 0, 0);
        ins_i = 1'b1;
        burst(1, 2'b00, 1'b0);
        cyc("b2b_start", 4'b1011, 1, 1, 0);
        start_i = 1'b0;
        cyc("b2b_done", 4'b0111, 1, 0, 1);
        burst(2, 2'b10, 1'b0);
        cyc("b2b_restart", 4'b0111, 1, 1, 0);
        start_i = 1'b0;
        cyc("b2b1", 4'b1110, 0, 1, 0);
        cyc("b2b2", 4'b1100, 1, 0, 1);
        cyc("b2b_idle", 4'b1100, 1, 0, 0);
        burst(2, 2'b11, 1'b1);
        cyc("hold_start", 4'b1100, 1, 1, 0);
        start_i = 1'b0;
        cyc("hold1", 4'b1100, 1, 1, 0);
        cyc("hold2", 4'b1100, 1, 0, 1);
        cyc("hold_idle", 4'b1100, 1, 0, 0);
        burst(7, 2'b01, 1'b1);
        cyc("abort_start", 4'b1100, 1, 1, 0);
        start_i = 1'b0;
        cyc("abort1", 4'b0110, 0, 1, 0);
        #2 rst_n = 1'b0;
        #1 now("abort_rst", 4'b0000, 0, 0, 0);
        cyc("abort_hold", 4'b0000, 0, 0, 0);
        #2 rst_n = 1'b1;
        cyc("abort_nodone1", 4'b0000, 0, 0, 0);
        cyc("abort_nodone2", 4'b0000, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
